// File: rtl/loss_batch_accum.sv
// Batch accumulator for per-sample loss: sums 2^BATCH_LOG2 samples and presents the batch mean via valid/ready.
// Define LOSS_ROUND_EN to round the mean half-up instead of truncating.
module loss_batch_accum #(
    parameter int LOSS_W     = 42,
    parameter int BATCH_LOG2 = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         loss_valid_i,
    input  logic [LOSS_W-1:0]            loss_i,
    output logic                         loss_ready_o,
    output logic                         mean_valid_o,
    input  logic                         mean_ready_i,
    output logic [LOSS_W-1:0]            mean_o,
    output logic [LOSS_W+BATCH_LOG2-1:0] sum_o,
    output logic [BATCH_LOG2:0]          sample_cnt_o,
    output logic                         busy_o
);

    localparam int SUM_W = LOSS_W + BATCH_LOG2;
    localparam int CNT_W = BATCH_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << BATCH_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SUM_W-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LOSS_W-1:0]  mean_q;
    logic [SUM_W-1:0]   sum_next;
    logic [LOSS_W-1:0]  mean_next;
    logic               sample_acc;
    logic               result_xfer;
    logic               last_sample;
    logic               clear_batch;

    assign sample_acc  = loss_valid_i & loss_ready_o;
    assign result_xfer = mean_valid_o & mean_ready_i;
    assign last_sample = sample_acc && (cnt_q == LAST_CNT);
    assign sum_next    = sum_q + SUM_W'(loss_i);
    // A new batch starts from IDLE, or straight out of HOLD when the result leaves on the same edge.
    assign clear_batch = start_i && ((state_q == IDLE) || result_xfer);

`ifdef LOSS_ROUND_EN
    localparam logic [SUM_W:0] HALF_LSB = (SUM_W + 1)'(1) << (BATCH_LOG2 - 1);
    logic [SUM_W:0] round_sum;
    logic [SUM_W:0] unused_round_shifted;

    assign round_sum            = {1'b0, sum_next} + HALF_LSB;
    assign unused_round_shifted = round_sum >> BATCH_LOG2;
    assign mean_next            = unused_round_shifted[LOSS_W-1:0];
`else
    assign mean_next = sum_next[SUM_W-1:BATCH_LOG2];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)     state_d = ACCUM;
            ACCUM:   if (last_sample) state_d = HOLD;
            HOLD:    if (result_xfer) state_d = start_i ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        loss_ready_o = (state_q == ACCUM);
        mean_valid_o = (state_q == HOLD);
        busy_o       = (state_q != IDLE);
    end

    // Mean is captured only on the final accept so it stays put through HOLD and afterwards in IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            mean_q <= '0;
        end else if (clear_batch) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if (sample_acc) begin
            sum_q <= sum_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_sample) begin
                mean_q <= mean_next;
            end
        end
    end

    assign sum_o        = sum_q;
    assign sample_cnt_o = cnt_q;
    assign mean_o       = mean_q;

endmodule
